// File: rtl/periph_req_arbiter.sv
// Round-robin arbiter that shares the peripheral memory server among p_num_reqs requesters.
// Optional statistics counters are compiled in when PERIPH_ARB_STATS_EN is defined.
module periph_req_arbiter #(
    parameter int p_num_reqs     = 2,
    parameter int p_msg_bits     = 77,
    parameter int p_max_inflight = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [p_num_reqs-1:0]            req_val,
    output logic [p_num_reqs-1:0]            req_rdy,
    input  logic [p_num_reqs*p_msg_bits-1:0] req_msg,
    output logic [p_num_reqs-1:0]            resp_val,
    input  logic [p_num_reqs-1:0]            resp_rdy,
    output logic [p_msg_bits-1:0]            resp_msg,
    output logic                             srv_req_val,
    input  logic                             srv_req_rdy,
    output logic [p_msg_bits-1:0]            srv_req_msg,
    input  logic                             srv_resp_val,
    output logic                             srv_resp_rdy,
    input  logic [p_msg_bits-1:0]            srv_resp_msg
`ifdef PERIPH_ARB_STATS_EN
    ,
    output logic [p_num_reqs*32-1:0]         grant_cnt,
    output logic [31:0]                      stall_cnt
`endif
);

    localparam int IW = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
    localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;
    localparam int CW = $clog2(p_max_inflight + 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(p_max_inflight);
    localparam logic [IW-1:0] LAST_REQ  = IW'(p_num_reqs - 1);
    localparam logic [PW-1:0] LAST_SLOT = PW'(p_max_inflight - 1);
    localparam logic [IW:0]   NUM_REQS  = (IW+1)'(p_num_reqs);

    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] r_fifo [p_max_inflight];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic                  w_full;
    logic                  w_empty;
    logic [p_num_reqs-1:0] w_eligible;
    logic [IW-1:0]         w_winner;
    logic                  w_found;
    logic [IW:0]           w_scan;
    logic [IW-1:0]         w_head;
    logic                  w_accept;
    logic                  w_pop;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    // Reset gates the eligible set so every output reads zero while rst is low.
    assign w_eligible = req_val & {p_num_reqs{~w_full & rst}};
    assign w_head     = r_fifo[r_rd_ptr];

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int k = 0; k < p_num_reqs; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IW+1)'(k);
            if (w_scan >= NUM_REQS) w_scan = w_scan - NUM_REQS;
            if (!w_found && w_eligible[w_scan[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[IW-1:0];
            end
        end
    end

    assign srv_req_val = |w_eligible;
    assign srv_req_msg = srv_req_val ? req_msg[w_winner*p_msg_bits +: p_msg_bits] : '0;

    always_comb begin
        req_rdy = '0;
        if (srv_req_val) req_rdy[w_winner] = srv_req_rdy;
    end

    always_comb begin
        resp_val = '0;
        if (rst && !w_empty) resp_val[w_head] = srv_resp_val;
    end

    assign srv_resp_rdy = rst & ~w_empty & resp_rdy[w_head];
    assign resp_msg     = rst ? srv_resp_msg : '0;

    assign w_accept = srv_req_val & srv_req_rdy;
    assign w_pop    = srv_resp_val & srv_resp_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < p_max_inflight; i++) r_fifo[i] <= '0;
        end else begin
            if (w_accept) begin
                r_fifo[r_wr_ptr] <= w_winner;
                r_wr_ptr         <= (r_wr_ptr == LAST_SLOT) ? '0 : r_wr_ptr + 1'b1;
                r_rr_ptr         <= (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == LAST_SLOT) ? '0 : r_rd_ptr + 1'b1;
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PERIPH_ARB_STATS_EN
    logic [31:0] r_grant_cnt [p_num_reqs];
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            for (int i = 0; i < p_num_reqs; i++) r_grant_cnt[i] <= '0;
        end else begin
            if (w_accept) r_grant_cnt[w_winner] <= r_grant_cnt[w_winner] + 32'd1;
            if ((|req_val) && !w_accept && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    for (genvar g = 0; g < p_num_reqs; g++) begin : g_grant_cnt
        assign grant_cnt[g*32 +: 32] = r_grant_cnt[g];
    end
    assign stall_cnt = r_stall_cnt;
`endif

`ifndef SYNTHESIS
    // A response with nothing in flight means the server and arbiter lost sync.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst) !(srv_resp_val && w_empty));
`endif

endmodule
